// File: rtl/redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : redirect_ctrl
// Description : Front-end redirect controller. Arbitrates trap, branch
//               misprediction and predictor redirects, sequences the
//               fetch/decode flush, and produces gap-separated predictor
//               feedback pulses with a saturating misprediction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_cond,
  input  logic            ex_pred_taken,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_fallthrough,
  input  logic            bpu_pc_write,
  input  logic [XLEN-1:0] bpu_pc_value,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  output logic            trap_ack,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_value,
  output logic            flush_n,
  output logic            stall,
  output logic            predict_ok,
  output logic            mispredict,
  output logic [15:0]     mispredict_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Counter reload value: FLUSH lasts FLUSH_CYCLES cycles including entry.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  logic [1:0]      state;
  logic [3:0]      flush_cnt;
  logic            pend_valid;
  logic            pend_mis;

  logic            in_idle;
  logic            ev_cond;
  logic            ev_mis;
  logic            ev_ok;
  logic            take_trap;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;

  // Classify the resolved branch and pick the winning redirect source.
  // Everything is gated by IDLE: results seen in FLUSH/DRAIN are wrong-path.
  always_comb begin
    in_idle   = (state == ST_IDLE);
    ev_cond   = in_idle & ex_valid & ex_is_cond;
    ev_mis    = ev_cond & (ex_taken != ex_pred_taken);
    ev_ok     = ev_cond & (ex_taken == ex_pred_taken);
    take_trap = in_idle & trap_req;
    redirect  = take_trap | ev_mis | (in_idle & bpu_pc_write);
    if (take_trap) begin
      redirect_addr = trap_vector;
    end else if (ev_mis) begin
      redirect_addr = ex_taken ? ex_target : ex_fallthrough;
    end else begin
      redirect_addr = bpu_pc_value;
    end
  end

  // Redirect sequencer: registered PC load, then flush, then one drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= 4'd0;
      pc_write  <= 1'b0;
      pc_value  <= '0;
      flush_n   <= 1'b1;
      stall     <= 1'b0;
      trap_ack  <= 1'b0;
    end else begin
      pc_write <= 1'b0;
      trap_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LAST;
            pc_write  <= 1'b1;
            pc_value  <= redirect_addr;
            trap_ack  <= take_trap;
            flush_n   <= 1'b0;
            stall     <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state   <= ST_DRAIN;
            flush_n <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          flush_n <= 1'b1;
          stall   <= 1'b0;
        end
      endcase
    end
  end

  // Predictor feedback: one-cycle pulses separated by a mandatory low cycle.
  // An event that lands on the low cycle waits in a single pending slot; a
  // misprediction may replace a waiting predict_ok, anything else is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_ok <= 1'b0;
      mispredict <= 1'b0;
      pend_valid <= 1'b0;
      pend_mis   <= 1'b0;
    end else if (predict_ok | mispredict) begin
      predict_ok <= 1'b0;
      mispredict <= 1'b0;
      if (!pend_valid && (ev_ok || ev_mis)) begin
        pend_valid <= 1'b1;
        pend_mis   <= ev_mis;
      end else if (pend_valid && !pend_mis && ev_mis) begin
        pend_mis <= 1'b1;
      end
    end else if (pend_valid) begin
      pend_valid <= 1'b0;
      pend_mis   <= 1'b0;
      mispredict <= pend_mis | ev_mis;
      predict_ok <= ~(pend_mis | ev_mis);
    end else begin
      predict_ok <= ev_ok;
      mispredict <= ev_mis;
    end
  end

  // Saturating count of mispredictions accepted in IDLE, trap-preempted ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_count <= 16'd0;
    end else if (ev_mis && (mispredict_count != 16'hFFFF)) begin
      mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_redirect_ctrl
// Description : Self-checking bench for redirect_ctrl. Expected redirects and
//               feedback pulses are queued with their due cycle and matched
//               against DUT output at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_cond, ex_pred_taken, ex_taken;
  logic [31:0] ex_target, ex_fallthrough;
  logic        bpu_pc_write;
  logic [31:0] bpu_pc_value;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        trap_ack, pc_write, flush_n, stall, predict_ok, mispredict;
  logic [31:0] pc_value;
  logic [15:0] mispredict_count;

  typedef struct {int cyc; logic [31:0] addr; logic trap;} redir_t;
  typedef struct {int cyc; logic mis;} fb_t;

  redir_t      rq[$];
  fb_t         fq[$];
  redir_t      re;
  fb_t         fe;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'd0;

  redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_cond(ex_is_cond),
    .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_fallthrough(ex_fallthrough),
    .bpu_pc_write(bpu_pc_write), .bpu_pc_value(bpu_pc_value),
    .trap_req(trap_req), .trap_vector(trap_vector), .trap_ack(trap_ack),
    .pc_write(pc_write), .pc_value(pc_value),
    .flush_n(flush_n), .stall(stall),
    .predict_ok(predict_ok), .mispredict(mispredict),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pc_write and feedback pulse must match a queued entry.
  always @(negedge clk) begin
    if (pc_write) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL redirect_unexpected cyc=%0d got pc_value=%h expected no pc_write", cyc, pc_value);
      end else begin
        re = rq.pop_front();
        if (re.cyc != cyc || re.addr !== pc_value || re.trap !== trap_ack) begin
          failures++;
          $display("FAIL redirect cyc=%0d got addr=%h ack=%b expected cyc=%0d addr=%h ack=%b",
                   cyc, pc_value, trap_ack, re.cyc, re.addr, re.trap);
        end
      end
    end else if (trap_ack) begin
      checks++;
      failures++;
      $display("FAIL trap_ack_alone cyc=%0d got trap_ack=1 expected 0 without pc_write", cyc);
    end
    if (rq.size() > 0 && rq[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL redirect_missing cyc=%0d expected addr=%h due cyc=%0d", cyc, rq[0].addr, rq[0].cyc);
      void'(rq.pop_front());
    end
    if (predict_ok || mispredict) begin
      checks++;
      if (predict_ok && mispredict) begin
        failures++;
        $display("FAIL feedback_both cyc=%0d got predict_ok=1 mispredict=1 expected one", cyc);
      end else if (fq.size() == 0) begin
        failures++;
        $display("FAIL feedback_unexpected cyc=%0d got ok=%b mis=%b expected none", cyc, predict_ok, mispredict);
      end else begin
        fe = fq.pop_front();
        if (fe.cyc != cyc || fe.mis !== mispredict) begin
          failures++;
          $display("FAIL feedback cyc=%0d got mis=%b expected cyc=%0d mis=%b", cyc, mispredict, fe.cyc, fe.mis);
        end
      end
    end
    if (fq.size() > 0 && fq[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL feedback_missing cyc=%0d expected mis=%b due cyc=%0d", cyc, fq[0].mis, fq[0].cyc);
      void'(fq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_pred_taken = 1'b0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_fallthrough = 32'h0;
    bpu_pc_write = 1'b0; bpu_pc_value = 32'h0;
    trap_req = 1'b0; trap_vector = 32'h0;
  endtask

  // Drive one misprediction; queue its redirect (unless preempted) and feedback.
  task automatic drive_mis(input logic pred, input logic [31:0] fall, input logic [31:0] tgt,
                           input logic push_rd, input int fb_delay);
    redir_t r;
    fb_t    f;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pred_taken = pred; ex_taken = ~pred;
    ex_fallthrough = fall; ex_target = tgt;
    if (push_rd) begin
      r.cyc = cyc + 1; r.addr = pred ? fall : tgt; r.trap = 1'b0;
      rq.push_back(r);
    end
    f.cyc = cyc + fb_delay; f.mis = 1'b1;
    fq.push_back(f);
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
  endtask

  task automatic drive_ok(input logic pred, input int fb_delay);
    fb_t f;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pred_taken = pred; ex_taken = pred;
    ex_target = 32'h0000_0F00; ex_fallthrough = 32'h0000_0F04;
    f.cyc = cyc + fb_delay; f.mis = 1'b0;
    fq.push_back(f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) step();
    checks++;
    if ({pc_write, trap_ack, flush_n, stall, predict_ok, mispredict} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_ctrl got %b expected 001000", {pc_write, trap_ack, flush_n, stall, predict_ok, mispredict});
    end
    checks++;
    if (pc_value !== 32'h0 || mispredict_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_regs got pc=%h cnt=%h expected 0 0", pc_value, mispredict_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mispredict();
    redir_t r;
    drive_mis(1'b1, 32'h104, 32'h200, 1'b1, 1);
    step();
    clear_inputs();
    checks++;
    if ({flush_n, stall} !== 2'b01 || mispredict_count !== exp_count) begin
      failures++;
      $display("FAIL mis_c1 got fn/st=%b cnt=%h expected 01 %h", {flush_n, stall}, mispredict_count, exp_count);
    end
    step();
    checks++;
    if ({flush_n, stall} !== 2'b01) begin
      failures++;
      $display("FAIL mis_c2 got fn/st=%b expected 01", {flush_n, stall});
    end
    step();
    checks++;
    if ({flush_n, stall} !== 2'b11) begin
      failures++;
      $display("FAIL mis_drain got fn/st=%b expected 11", {flush_n, stall});
    end
    step();
    checks++;
    if ({flush_n, stall} !== 2'b10 || pc_value !== 32'h104) begin
      failures++;
      $display("FAIL mis_idle got fn/st=%b pc=%h expected 10 00000104", {flush_n, stall}, pc_value);
    end
    // Taken-side correction uses the branch target.
    drive_mis(1'b0, 32'h300, 32'h440, 1'b1, 1);
    step();
    clear_inputs();
    repeat (3) step();
    checks++;
    if (pc_value !== 32'h440 || mispredict_count !== exp_count) begin
      failures++;
      $display("FAIL mis_taken got pc=%h cnt=%h expected 00000440 %h", pc_value, mispredict_count, exp_count);
    end
    r.cyc = 0;
  endtask

  task automatic test_priority();
    redir_t r;
    trap_req = 1'b1; trap_vector = 32'h80;
    bpu_pc_write = 1'b1; bpu_pc_value = 32'h500;
    drive_mis(1'b0, 32'h600, 32'h700, 1'b0, 1);
    r.cyc = cyc + 1; r.addr = 32'h80; r.trap = 1'b1;
    rq.push_back(r);
    step();
    clear_inputs();
    checks++;
    if (trap_ack !== 1'b1 || mispredict_count !== exp_count) begin
      failures++;
      $display("FAIL prio got ack=%b cnt=%h expected 1 %h", trap_ack, mispredict_count, exp_count);
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    drive_ok(1'b1, 1);
    step();
    drive_ok(1'b0, 2);
    step();
    clear_inputs();
    checks++;
    if ({predict_ok, mispredict} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_gap got ok/mis=%b expected 00", {predict_ok, mispredict});
    end
    step();
    checks++;
    if (predict_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got predict_ok=%b expected 1", predict_ok);
    end
    step();
    // Correct prediction then misprediction: mispredict waits out the gap.
    drive_ok(1'b1, 1);
    step();
    drive_mis(1'b1, 32'h900, 32'hA00, 1'b1, 2);
    step();
    clear_inputs();
    checks++;
    if (mispredict !== 1'b0) begin
      failures++;
      $display("FAIL gap_mis got mispredict=%b expected 0", mispredict);
    end
    repeat (3) step();
  endtask

  task automatic test_wrong_path();
    redir_t r;
    logic [15:0] cnt_before;
    cnt_before = mispredict_count;
    bpu_pc_write = 1'b1; bpu_pc_value = 32'hB00;
    r.cyc = cyc + 1; r.addr = 32'hB00; r.trap = 1'b0;
    rq.push_back(r);
    step();
    bpu_pc_value = 32'hC00;
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_pred_taken = 1'b1; ex_taken = 1'b0;
    ex_fallthrough = 32'hD00;
    repeat (2) step();
    clear_inputs();
    checks++;
    if ({flush_n, stall} !== 2'b11 || mispredict_count !== cnt_before) begin
      failures++;
      $display("FAIL wrong_path got fn/st=%b cnt=%h expected 11 %h", {flush_n, stall}, mispredict_count, cnt_before);
    end
    trap_req = 1'b1; trap_vector = 32'h90;
    r.cyc = cyc + 2; r.addr = 32'h90; r.trap = 1'b1;
    rq.push_back(r);
    step();
    checks++;
    if (pc_write !== 1'b0) begin
      failures++;
      $display("FAIL trap_drain_early got pc_write=%b expected 0", pc_write);
    end
    step();
    clear_inputs();
    repeat (4) step();
  endtask

  task automatic test_saturation();
    force dut.mispredict_count = 16'hFFFC;
    step();
    release dut.mispredict_count;
    exp_count = 16'hFFFC;
    step();
    checks++;
    if (mispredict_count !== 16'hFFFC) begin
      failures++;
      $display("FAIL sat_preload got %h expected FFFC", mispredict_count);
    end
    for (int i = 0; i < 5; i++) begin
      drive_mis(1'b1, 32'h1000 + 32'(i * 4), 32'h2000, 1'b1, 1);
      step();
      clear_inputs();
      checks++;
      if (mispredict_count !== exp_count) begin
        failures++;
        $display("FAIL sat_step%0d got %h expected %h", i, mispredict_count, exp_count);
      end
      repeat (3) step();
    end
  endtask

  task automatic test_reset_mid_flush();
    redir_t r;
    bpu_pc_write = 1'b1; bpu_pc_value = 32'hE00;
    r.cyc = cyc + 1; r.addr = 32'hE00; r.trap = 1'b0;
    rq.push_back(r);
    step();
    clear_inputs();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({flush_n, stall} !== 2'b10 || pc_value !== 32'h0 || pc_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got fn/st=%b pc=%h wr=%b expected 10 0 0", {flush_n, stall}, pc_value, pc_write);
    end
    repeat (2) step();
    rst_n = 1'b1;
    exp_count = 16'd0;
    repeat (5) step();
    checks++;
    if ({pc_write, trap_ack, flush_n, stall, predict_ok, mispredict} !== 6'b001000
        || mispredict_count !== exp_count || pc_value !== 32'h0) begin
      failures++;
      $display("FAIL rst_after got ctrl=%b cnt=%h pc=%h expected 001000 0 0",
               {pc_write, trap_ack, flush_n, stall, predict_ok, mispredict}, mispredict_count, pc_value);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_priority();
    test_back_to_back();
    test_wrong_path();
    test_saturation();
    test_reset_mid_flush();
    repeat (3) step();
    checks++;
    if (rq.size() != 0 || fq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got redirects=%0d feedback=%0d expected 0 0", rq.size(), fq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
